// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown timer: debounced buttons, IDLE/RUN/PAUSE/EXPIRED FSM, 7-seg and LED drive.
// Latency: press -> 2-FF sync + DB_CYCLES debounce -> 1-cycle pulse -> FSM edge -> registered outputs (+1).
// Backpressure: none; button pulses are consumed on the cycle they appear, lower-priority ones dropped.
// Optional: define ALARM_BLINK_EN to blink LED[15:8] at the tick rate while EXPIRED.
module countdown_timer_ctrl #(
    parameter int TICK_DIV  = 25175000,
    parameter int DB_CYCLES = 251750
) (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic [3:0]  BT,
    output logic [6:0]  DISP1,
    output logic [6:0]  DISP2,
    output logic [6:0]  DISP3,
    output logic [6:0]  DISP4,
    output logic        DISP1_DP,
    output logic        DISP2_DP,
    output logic        DISP3_DP,
    output logic        DISP4_DP,
    output logic [15:0] LED
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICK_DIV / 2);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } bcd_time_t;

    // ---------------------------------------------------------------
    // Button conditioning (buttons are active-low; 1 = released)
    // ---------------------------------------------------------------
    logic [3:0]    bt_s1_q, bt_s2_q;
    logic [3:0]    db_lvl_q;
    logic [DW-1:0] db_cnt_q [4];
    logic [3:0]    press_q;

    // Two-flop synchronizer on the raw button pins.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            bt_s1_q <= 4'hF;
            bt_s2_q <= 4'hF;
        end else begin
            bt_s1_q <= BT;
            bt_s2_q <= bt_s1_q;
        end
    end

    // Accept a new level only after it has differed from the accepted one for DB_CYCLES cycles;
    // emit a single-cycle pulse on an accepted released->pressed transition.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            db_lvl_q <= 4'hF;
            press_q  <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= 1'b0;
                if (bt_s2_q[i] != db_lvl_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_lvl_q[i] <= bt_s2_q[i];
                        db_cnt_q[i] <= '0;
                        press_q[i]  <= ~bt_s2_q[i];
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Priority resolution: CLEAR > START > MIN+ > SEC+.
    logic cmd_clr, cmd_start, cmd_min, cmd_sec;
    assign cmd_clr   = press_q[3];
    assign cmd_start = press_q[0] & ~press_q[3];
    assign cmd_min   = press_q[1] & ~press_q[3] & ~press_q[0];
    assign cmd_sec   = press_q[2] & ~press_q[3] & ~press_q[0] & ~press_q[1];

    // ---------------------------------------------------------------
    // Timer state
    // ---------------------------------------------------------------
    state_t        state_q, state_d;
    bcd_time_t     time_q, time_d;
    bcd_time_t     preset_q, preset_d;
    logic [TW-1:0] tick_q, tick_d;

    function automatic bcd_time_t inc_min(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.m1 == 4'd9) begin
            r.m1  = 4'd0;
            r.m10 = (t.m10 == 4'd9) ? 4'd0 : t.m10 + 4'd1;
        end else begin
            r.m1 = t.m1 + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t inc_sec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s1 == 4'd9) begin
            r.s1  = 4'd0;
            r.s10 = (t.s10 == 4'd5) ? 4'd0 : t.s10 + 4'd1;
        end else begin
            r.s1 = t.s1 + 4'd1;
        end
        return r;
    endfunction

    // One-second decrement with the borrow chain S1 -> S10 -> M1 -> M10.
    // Never applied at 00:00: RUN is only entered with a non-zero time.
    function automatic bcd_time_t dec_sec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s1 != 4'd0) begin
            r.s1 = t.s1 - 4'd1;
        end else begin
            r.s1 = 4'd9;
            if (t.s10 != 4'd0) begin
                r.s10 = t.s10 - 4'd1;
            end else begin
                r.s10 = 4'd5;
                if (t.m1 != 4'd0) begin
                    r.m1 = t.m1 - 4'd1;
                end else begin
                    r.m1  = 4'd9;
                    r.m10 = t.m10 - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // FSM, time and tick counter state registers.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            time_q   <= '0;
            preset_q <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            preset_q <= preset_d;
            tick_q   <= tick_d;
        end
    end

    // Next-state logic for the FSM, time digits and tick counter.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        preset_d = preset_q;
        tick_d   = tick_q;
        if (cmd_clr) begin
            state_d  = ST_IDLE;
            time_d   = '0;
            preset_d = '0;
            tick_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        if (time_q != '0) begin
                            preset_d = time_q;
                            tick_d   = '0;
                            state_d  = ST_RUN;
                        end
                    end else if (cmd_min) begin
                        time_d = inc_min(time_q);
                    end else if (cmd_sec) begin
                        time_d = inc_sec(time_q);
                    end
                end
                ST_RUN: begin
                    if (cmd_start) begin
                        // Pausing wins over a coincident tick; the count is held as-is.
                        state_d = ST_PAUSE;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        time_d = dec_sec(time_q);
                        if (dec_sec(time_q) == '0) state_d = ST_EXPIRED;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (cmd_start) state_d = ST_RUN;
                end
                ST_EXPIRED: begin
                    if (cmd_start) begin
                        state_d = ST_IDLE;
                        time_d  = preset_q;
                        tick_d  = '0;
                    end else begin
`ifdef ALARM_BLINK_EN
                        tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
`else
                        tick_d = '0;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output drive (all active-low)
    // ---------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic        tick_hi;
    logic        colon_d;
    logic [15:0] led_d;
    assign tick_hi = (tick_q >= TICK_HALF);

    // Colon and LED values derived from the current state.
    always_comb begin
        colon_d = 1'b0;
        led_d   = 16'hFFFF;
        case (state_q)
            ST_RUN: begin
                colon_d   = tick_hi;
                led_d[0]  = 1'b0;
            end
            ST_PAUSE: led_d[1] = 1'b0;
            ST_EXPIRED: begin
                led_d[2] = 1'b0;
`ifdef ALARM_BLINK_EN
                led_d[15:8] = tick_hi ? 8'hFF : 8'h00;
`else
                led_d[15:8] = 8'h00;
`endif
            end
            default: ;
        endcase
    end

    // Registered display and LED outputs, one cycle behind the timer state.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            DISP1    <= 7'b1000000;
            DISP2    <= 7'b1000000;
            DISP3    <= 7'b1000000;
            DISP4    <= 7'b1000000;
            DISP1_DP <= 1'b1;
            DISP2_DP <= 1'b1;
            DISP3_DP <= 1'b1;
            DISP4_DP <= 1'b1;
            LED      <= 16'hFFFF;
        end else begin
            DISP1    <= seg7(time_q.m10);
            DISP2    <= seg7(time_q.m1);
            DISP3    <= seg7(time_q.s10);
            DISP4    <= seg7(time_q.s1);
            DISP1_DP <= 1'b1;
            DISP2_DP <= colon_d;
            DISP3_DP <= 1'b1;
            DISP4_DP <= 1'b1;
            LED      <= led_d;
        end
    end

endmodule
